// File: rtl/mac_pkg.sv
// Shared sizing constants for the multiply-accumulate unit.
// Operand width default plus the product and accumulator width ratios.
package mac_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int ACC_MULT       = 3;
  localparam int PROD_MULT      = 2;

  function automatic int prod_width(input int dw);
    return PROD_MULT * dw;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// First pipeline stage: registered unsigned product and its valid bit.
// Clear and reset both flush the stage so nothing in flight survives.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PW         = prod_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [PW-1:0]         prod,
  output logic                  valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      prod  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      // Hold the old product while idle; valid alone gates accumulation.
      if (en)
        prod <= PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/mac_unit.sv
// Two-stage unsigned multiply-accumulate with wrapping accumulator.
// Stage 1 lives in mac_mult_stage; stage 2 is the accumulator below.
module mac_unit
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = ACC_MULT * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  En,
  input  logic                  Clr,
  input  logic [DATA_WIDTH-1:0] Ain,
  input  logic [DATA_WIDTH-1:0] Bin,
  output logic [ACC_WIDTH-1:0]  Cout
);

  localparam int PW = prod_width(DATA_WIDTH);

  logic [PW-1:0] prod;
  logic          valid;

  mac_mult_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .PW        (PW)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .clr  (Clr),
    .en   (En),
    .a    (Ain),
    .b    (Bin),
    .prod (prod),
    .valid(valid)
  );

  // Sum wraps naturally at ACC_WIDTH bits.
  always_ff @(posedge clk) begin
    if (rst)
      Cout <= '0;
    else if (Clr)
      Cout <= '0;
    else if (valid)
      Cout <= Cout + ACC_WIDTH'(prod);
  end

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit with a cycle model feeding a scoreboard.
// Each step queues the expected Cout and checks it after the edge.
module tb_mac_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        En  = 1'b0;
  logic        Clr = 1'b0;
  logic [7:0]  Ain = '0;
  logic [7:0]  Bin = '0;
  logic [23:0] Cout;

  logic [23:0] m_acc = '0;
  logic [15:0] m_p   = '0;
  logic        m_v   = 1'b0;
  logic [23:0] sb_q[$];

  int passed = 0;
  int total  = 0;

  mac_unit dut (
    .clk (clk),
    .rst (rst),
    .En  (En),
    .Clr (Clr),
    .Ain (Ain),
    .Bin (Bin),
    .Cout(Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] exp);
    total++;
    assert (Cout === exp) passed++;
    else
      $error("FAIL %s: Cout=%0d expected=%0d", tag, Cout, exp);
  endtask

  task automatic step(input string tag, input logic r, input logic c,
                      input logic e, input logic [7:0] a,
                      input logic [7:0] b);
    logic [23:0] exp;
    @(negedge clk);
    rst = r;
    Clr = c;
    En  = e;
    Ain = a;
    Bin = b;
    if (r || c) begin
      m_acc = '0;
      m_p   = '0;
      m_v   = 1'b0;
    end else begin
      if (m_v)
        m_acc = m_acc + {8'd0, m_p};
      m_v = e;
      if (e)
        m_p = {8'd0, a} * {8'd0, b};
    end
    sb_q.push_back(m_acc);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check(tag, exp);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    step("reset0", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    step("reset1", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    idle("post_reset");
    check("reset_zero", 24'd0);

    step("acc_2x3", 1'b0, 1'b0, 1'b1, 8'd2, 8'd3);
    step("acc_4x5", 1'b0, 1'b0, 1'b1, 8'd4, 8'd5);
    step("acc_6x7", 1'b0, 1'b0, 1'b1, 8'd6, 8'd7);
    step("acc_8x9", 1'b0, 1'b0, 1'b1, 8'd8, 8'd9);
    idle("drain");
    check("sum_140", 24'd140);
    idle("hold0");
    idle("hold1");
    check("hold_140", 24'd140);

    step("clr0", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    check("clr_zero", 24'd0);
    step("clr1", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    idle("after_clr");

    step("pre_1x5", 1'b0, 1'b0, 1'b1, 8'd1, 8'd5);
    idle("pre_drain");
    check("pre_5", 24'd5);
    step("clr_en_10x10", 1'b0, 1'b1, 1'b1, 8'd10, 8'd10);
    idle("no_100_a");
    idle("no_100_b");
    check("clr_wins", 24'd0);

    step("fly_2x2", 1'b0, 1'b0, 1'b1, 8'd2, 8'd2);
    step("fly_clr", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    idle("fly_after");
    step("resume_3x4", 1'b0, 1'b0, 1'b1, 8'd3, 8'd4);
    idle("resume_drain");
    check("resume_12", 24'd12);

    step("wrap_clr", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 259; i++)
      step("wrap_ff", 1'b0, 1'b0, 1'b1, 8'd255, 8'd255);
    idle("wrap_drain");
    check("wrap_64259", 24'd64259);

    step("rst_3x3", 1'b0, 1'b0, 1'b1, 8'd3, 8'd3);
    step("rst_mid", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    check("rst_discard", 24'd0);
    idle("rst_after0");
    idle("rst_after1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
